// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 16x-oversampled UART receive engine.
// Synchronises rx, validates the start bit, recovers each bit with a 3-sample
// majority vote at tick_cnt 7/8/9 and checks the stop bit. Each received word
// is presented on data_out with a single-cycle data_valid strobe.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data and stop bits, a PARITY_ODD parameter and a parity_err output.
module uart_rx_oversampler #(
    parameter int DATA_BITS   = 8,   // 5..9, LSB first
    parameter int OVERSAMPLE  = 16,  // must be 16 to match the clock handler
    parameter int SYNC_STAGES = 2    // 2..3
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0 // 0 = even parity, 1 = odd parity
`endif
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active-low
    input  logic                 clk_16bd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 rx_busy
);

    localparam int         BW        = $clog2(DATA_BITS);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] VOTE_TICK = 4'd9;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    // Front end: synchroniser chain and 16x-baud edge detector.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bd_q;
    logic                   bd_prev_q;
    logic                   rx_s;
    logic                   tick;

    // FSM and datapath state.
    state_t                 state_q,   state_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q,  bit_cnt_d;
    logic [1:0]             samp_q,     samp_d;     // samples taken at tick 7 and 8
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic [DATA_BITS-1:0]   data_q,     data_d;
    logic                   valid_q,    valid_d;
    logic                   ferr_q,     ferr_d;
    logic                   wait_high_q, wait_high_d; // set after a frame error
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q,  par_bad_d;
    logic                   perr_q,     perr_d;
`endif

    logic vote;
    logic at_vote;
    logic at_last;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign tick    = bd_q & ~bd_prev_q;
    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign at_vote = (tick_cnt_q == VOTE_TICK);
    assign at_last = (tick_cnt_q == LAST_TICK);

    // Synchronise rx (idle-high reset) and register clk_16bd for edge detection.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            bd_q      <= 1'b0;
            bd_prev_q <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            else                 sync_q <= rx;
            bd_q      <= clk_16bd;
            bd_prev_q <= bd_q;
        end
    end

    // Next-state and datapath logic; everything advances only on tick.
    // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ferr_d      = ferr_q;
        wait_high_d = wait_high_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        perr_d      = perr_q;
`endif
        if (tick) begin
            if (state_q != ST_IDLE) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd7) samp_d[0] = rx_s;
                if (tick_cnt_q == 4'd8) samp_d[1] = rx_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (wait_high_q) begin
                        // After a frame error, require the line to return high first.
                        if (rx_s) wait_high_d = 1'b0;
                    end else if (!rx_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = 4'd0;
                    end
                end
                ST_START: begin
                    if (at_vote && vote) begin
                        state_d    = ST_IDLE;   // false start, outputs untouched
                        tick_cnt_d = 4'd0;
                    end else if (at_last) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (at_last) begin
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (at_vote) par_bad_d = ((^shift_q) ^ vote) != PARITY_ODD;
                    if (at_last) state_d = ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (at_vote) begin
                        // Deliver at mid stop bit so a back-to-back start is not missed.
                        data_d      = shift_q;
                        ferr_d      = ~vote;
                        valid_d     = 1'b1;
                        wait_high_d = ~vote;
`ifdef UART_RX_PARITY_EN
                        perr_d      = par_bad_q;
`endif
                        state_d     = ST_IDLE;
                        tick_cnt_d  = 4'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register for the FSM, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            wait_high_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            wait_high_q <= wait_high_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler: scoreboard bench for uart_rx_oversampler.
// Stimulus drives whole serial frames on rx and pushes the expected word into
// a queue; a monitor pops and compares on every data_valid pulse.
// Define UART_RX_PARITY_EN to also exercise the parity bit and parity_err.
module tb_uart_rx_oversampler;

    localparam int  DW         = 8;
    localparam int  CLK_NS     = 10;
    localparam int  TICK_NS    = 4 * CLK_NS;     // clk_16bd = clk/4
    localparam int  BIT_NS     = 16 * TICK_NS;
    localparam bit  PARITY_ODD = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          clk_16bd = 1'b0;
    logic          rx       = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          rx_busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    uart_rx_oversampler dut (
        .clk        (clk),
        .rst        (rst),
        .clk_16bd   (clk_16bd),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .rx_busy    (rx_busy)
    );

    always #(CLK_NS / 2) clk = ~clk;
    always #(TICK_NS / 2) clk_16bd = ~clk_16bd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: a frame delivers its data; frame error is an inverted stop
    // bit; parity error is a parity-bit mismatch against the chosen sense.
    task automatic send_frame(input logic [DW-1:0] d, input logic par_bit, input logic stop_bit);
        exp_t e;
        e.data = d;
        e.ferr = ~stop_bit;
        e.perr = ((^d) ^ par_bit) != PARITY_ODD;
        exp_q.push_back(e);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        #(BIT_NS);
`endif
        rx = stop_bit;
        #(BIT_NS);
    endtask

    task automatic good_frame(input logic [DW-1:0] d);
        send_frame(d, (^d) ^ PARITY_ODD, 1'b1);
    endtask

    // Bounded wait for the monitor to consume every expected word.
    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compare each valid pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (data_valid) begin
            check("valid_single_cycle", prev_valid, 1'b0);
            check("valid_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", data_out, e.data);
                check("frame_err", frame_err, e.ferr);
`ifdef UART_RX_PARITY_EN
                check("parity_err", parity_err, e.perr);
`endif
            end
        end
        prev_valid <= data_valid;
    end

    initial begin
        logic [DW-1:0] d;
        logic          stop_bit;
        int            gap;

        // Reset state, both while asserted and just after release.
        #(100);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
        #(3) rst = 1'b1;
        #(BIT_NS);
        check("post_rst_data_out", data_out, 0);
        check("post_rst_rx_busy", rx_busy, 0);

        // Single 0x55 frame, rx_busy high mid-frame and low after.
        fork
            good_frame(8'h55);
            begin
                #(3 * BIT_NS);
                check("busy_mid_frame", rx_busy, 1'b1);
            end
        join
        check("busy_after_frame", rx_busy, 1'b0);
        wait_drain("drain_55");

        // Short glitch: false start aborts with no output change.
        rx = 1'b0;
        #(4 * TICK_NS - 5);
        check("busy_in_glitch", rx_busy, 1'b1);
        #(5) rx = 1'b1;
        #(2 * BIT_NS);
        check("glitch_busy", rx_busy, 1'b0);
        check("glitch_data_out", data_out, 8'h55);

        // Framing error, then a long break that must not retrigger.
        send_frame(8'hA3, ^8'hA3, 1'b0);
        #(12 * BIT_NS);
        wait_drain("drain_a3");
        check("break_busy", rx_busy, 1'b0);
        rx = 1'b1;
        #(BIT_NS);
        good_frame(8'h3C);
        wait_drain("drain_3c");

        // Back-to-back frames with no idle gap.
        good_frame(8'hA5);
        good_frame(8'h3C);
        #(BIT_NS);
        wait_drain("drain_b2b");

        // Reset during bit 4, then a clean frame.
        d  = 8'(($urandom & 32'h6E) | 32'h10);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = d[4];
        #(BIT_NS / 2);
        rst = 1'b0;
        #(30);
        check("midrst_busy", rx_busy, 1'b0);
        check("midrst_valid", data_valid, 1'b0);
        check("midrst_data_out", data_out, 0);
        rx = 1'b1;
        #(20) rst = 1'b1;
        #(2 * BIT_NS);
        check("after_midrst_busy", rx_busy, 1'b0);
        good_frame(8'h81);
        wait_drain("drain_81");
        check("hold_81", data_out, 8'h81);

`ifdef UART_RX_PARITY_EN
        // Correct then incorrect even-parity bit on 0x07.
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_drain("drain_parity");
`endif

        // Randomised frames with occasional framing errors and idle gaps.
        for (int n = 0; n < 24; n++) begin
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            gap      = $urandom_range(0, 2);
            if (!stop_bit && gap == 0) gap = 1;
            send_frame(d, (^d) ^ PARITY_ODD ^ 1'($urandom_range(0, 1)), stop_bit);
            rx = 1'b1;
            #(gap * BIT_NS);
        end
        #(BIT_NS);
        wait_drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
- UART receive engine fed by the 16x baud-tick output (clk_16bd) of the baud clock handler; sits directly downstream of it in the UART datapath.
- Synchronises the asynchronous rx line, detects and validates start bits, recovers the data bits with 3-sample majority voting, and checks the stop bit.
- Presents each received byte with a single-cycle valid strobe to the downstream consumer.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- OVERSAMPLE, 16, tick_16bd pulses per bit; must be 16, to match the clock handler.
- SYNC_STAGES, 2, flip-flop stages on rx; legal range 2..3.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); sync deassert is handled externally.
- clk_16bd  input  1  16x baud signal from the clock handler; treated as a level, rising edge is detected internally.
- rx  input  1  serial line; idles high.
- data_out  output  DATA_BITS  last received word, held until the next frame completes.
- data_valid  output  1  one clk-cycle pulse when data_out is updated.
- frame_err  output  1  stop bit sampled low; qualified by data_valid.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: data_out=0, data_valid=0, frame_err=0, rx_busy=0. Internal state: FSM=IDLE, sync chain all 1s, counters 0.
- Tick: tick=1 for one clk when the registered clk_16bd goes from 0 to 1. All sampling and counting advance only on tick.
- rx passes through SYNC_STAGES flops; rx_s is the synchronised value.
- tick_cnt is 4 bits and wraps 15->0. bit_cnt runs 0..DATA_BITS-1.
- Majority vote: rx_s is sampled at tick_cnt 7, 8 and 9. The bit value is the majority of the three, decided on the tick where tick_cnt=9.
- IDLE -> START on a tick with rx_s=0; tick_cnt is cleared to 0 on that tick.
- START:
  - At the vote: a majority of 1 is a false start; return to IDLE with no outputs changed.
  - Otherwise, at tick_cnt=15 go to DATA with bit_cnt=0.
- DATA:
  - At the vote, shift the bit into the shift register (LSB first).
  - At tick_cnt=15: if bit_cnt=DATA_BITS-1, go to PARITY (macro defined) or STOP; else bit_cnt+1.
- STOP, at the vote:
  - Load data_out from the shift register.
  - Set frame_err to the inverse of the vote.
  - Pulse data_valid on the next clk edge.
  - Go to IDLE immediately. The remaining half stop bit is not waited for, so a back-to-back start bit is caught.
- A frame error still delivers data. After a frame error, IDLE waits for rx_s=1 on one tick before accepting a new start, so a break condition does not retrigger.
- data_valid and frame_err are registered and are never high for more than one clk per frame.
- Asynchronous reset mid-frame: all state clears immediately, no data_valid is produced, and reception restarts from IDLE after reset release.
- If clk_16bd stops mid-frame, the FSM holds its state indefinitely; there is no timeout.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, plus a parameter PARITY_ODD (default 0 = even) and an output parity_err (1 bit, reset 0).
  - Parity is checked against the voted parity bit.
  - parity_err is updated together with data_out and qualified by data_valid.
- Undefined: no PARITY state, no PARITY_ODD parameter and no parity_err port; frame length = 1+DATA_BITS+1 bits.

Test Plan:
- Frame 0x55 with stop=1, clk_16bd = clk/4 -> exactly one data_valid pulse; data_out=0x55, frame_err=0; rx_busy high from start detect to the stop vote.
- rx glitch low for 4 ticks then high -> START aborts at the vote; returns to IDLE, no data_valid, data_out unchanged.
- Frame 0xA3 with stop bit driven 0 -> data_valid with data_out=0xA3 and frame_err=1. Next frame 0x3C is accepted only after rx returns high; then frame_err=0.
- Back-to-back 0xA5 then 0x3C with no idle gap -> two data_valid pulses, with values in order.
- Assert rst low during bit 4 of a frame, then release and send 0x81 -> no valid for the aborted frame; data_out=0x81 afterwards.
- With UART_RX_PARITY_EN defined and PARITY_ODD=0, send 0x07 with parity bit 1 and then parity bit 0 -> parity_err=0 then parity_err=1, each with data_out=0x07.
